video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Video stream source producing an RGB pixel stream with HSync/VSync/LineValid/FrameValid in the same format consumed by the grayscale conversion path. It drives the color-space pipeline for bring-up and regression without a camera. It generates raster timing from h/v counters and fills active pixels with one of four selectable test patterns.

## Interface

Parameters:
- H_ACTIVE, 640, active pixels per line (multiple of 8)
- H_FRONT, 16, horizontal front porch, cycles
- H_SYNC, 96, horizontal sync width, cycles
- H_BACK, 48, horizontal back porch, cycles
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BACK, 33, vertical back porch, lines
- CHK_LOG2, 4, checkerboard square size = 2^CHK_LOG2 pixels

Ports:
- iClk  in  1  pixel clock; single clock domain
- iRst_n  in  1  asynchronous, active-low reset
- iEn  in  1  run request
- iMode  in  2  pattern: 0 color bars, 1 gray ramp, 2 checkerboard, 3 solid
- iSolid  in  24  solid color {R,G,B} for mode 3
- oR, oG, oB  out  8 each  pixel data
- oHSync  out  1  high during horizontal sync region
- oVSync  out  1  high during vertical sync lines
- oLineValid  out  1  high on active pixels only
- oFrameValid  out  1  high for all cycles of active lines (vCnt < V_ACTIVE)
- oBusy  out  1  high while state is RUN or DRAIN

## Operation

- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. hCnt in 0..H_TOTAL-1, vCnt in 0..V_TOTAL-1; hCnt wraps to 0 and vCnt increments at hCnt = H_TOTAL-1; vCnt wraps at V_TOTAL-1.
- Horizontal regions by hCnt: active [0,H_ACTIVE), front, sync, back in that order. Vertical regions by vCnt identically.
- HSync = h in sync region (every line, including vertical blanking). VSync = v in sync region, whole lines.
- LineValid = hActive AND vActive. FrameValid = vActive.
- States: IDLE (counters held at 0, all outputs deasserted/zero), RUN, DRAIN.
  - IDLE -> RUN when iEn = 1; counters start at (0,0) that cycle.
  - RUN -> DRAIN when iEn = 0 and not at last cycle of frame; RUN -> IDLE when iEn = 0 at last cycle (hCnt=H_TOTAL-1, vCnt=V_TOTAL-1).
  - DRAIN -> IDLE at last cycle of frame; DRAIN -> RUN if iEn returns to 1 before then. Frames are never truncated.
  - RUN at last cycle with iEn = 1: wraps to (0,0), next frame begins with no gap.
- iMode and iSolid latched into shadow registers at every frame start (count (0,0)); mid-frame changes take effect next frame.
- Patterns (active pixels only; blanking RGB = 0):
  - Bars: 8 bars of H_ACTIVE/8 pixels, left to right white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00). Bar index from a bar-width counter, no divider.
  - Ramp: R=G=B=hCnt[7:0] (wraps every 256 px).
  - Checker: ((hCnt>>CHK_LOG2) ^ (vCnt>>CHK_LOG2)) bit 0 = 1 -> 0xFFFFFF, else 0x000000.
  - Solid: latched iSolid.
- Reset (any cycle, including mid-frame): state IDLE, counters 0, shadow mode 0, all outputs 0, oBusy 0. No partial-frame completion after reset.

## Timing

- All outputs registered. Output at edge N+1 reflects counter state at cycle N: one-cycle latency, identical for all outputs, so sync and pixel data are always aligned.
- iEn sampled high in IDLE at edge E -> counters at (0,0) for cycle after E -> first oLineValid and pixel (0,0) appear one edge later.
- Frame period exactly H_TOTAL*V_TOTAL cycles; line period exactly H_TOTAL cycles.
- oBusy is registered with the other outputs, falling one edge after the last frame cycle.

## Structure

- Package video_pattern_pkg: mode encoding constants, color-bar 8x24-bit LUT, state encoding, default 640x480 timing constants.
- Sub-module video_timing_counter: h/v counters, wrap, region flags (hActive, hSync, vActive, vSync, lastCycle); reusable by future timing-driven blocks. Top holds FSM, shadow registers, pattern mux, output registers.

## Test plan

Use H 16/2/3/3 (H_TOTAL 24), V 4/1/2/1 (V_TOTAL 8), CHK_LOG2 1.
- Reset, iEn 1 -> first oLineValid one cycle after counters leave (0,0) state; 16 valid cycles per line, 24-cycle line period, 4 valid lines, 192-cycle frame; oHSync high hCnt 18..20 each line; oVSync high lines 5..6.
- Mode 0 -> pixel pairs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; RGB 0 in blanking.
- Mode 2 -> line 0 pattern 000000 x2, FFFFFF x2 repeating; line 2 inverted; mode switched to 3 (iSolid 0x123456) mid-frame -> change visible only from next frame's pixel (0,0).
- iEn dropped at cycle 50 of a frame -> frame completes to 192 cycles, oBusy falls next edge, outputs stay 0 afterward; iEn re-raised during DRAIN -> next frame follows with no gap.
- iRst_n asserted asynchronously mid-line (between edges) -> all outputs 0 immediately; after release with iEn 1, full frame from (0,0).

Source files
------------

// File: rtl/video_pattern_pkg.sv
// Shared definitions for the video test-pattern source: pattern mode and
// FSM encodings, the RGB pixel struct, the color-bar lookup table and the
// default 640x480 raster timing.
package video_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Default 640x480 timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue,
    // black. Written MSB first, so BAR_LUT[0] is white.
    localparam logic [7:0][23:0] BAR_LUT = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with region flags.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           advance the raster position by one pixel
//   h_cnt/v_cnt  current position (0..TOTAL-1)
//   h_active, h_sync, v_active, v_sync   region flags for the current position
//   line_last    last pixel of a line; frame_last  last pixel of a frame
module video_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_active,
    output logic          h_sync,
    output logic          v_active,
    output logic          v_sync,
    output logic          line_last,
    output logic          frame_last
);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    assign h_active   = (h_cnt < H_ACT_END);
    assign h_sync     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign v_active   = (v_cnt < V_ACT_END);
    assign v_sync     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign line_last  = (h_cnt == H_LAST);
    assign frame_last = line_last && (v_cnt == V_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (line_last) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// RGB test-pattern video source with HSync/VSync/LineValid/FrameValid.
// Ports:
//   iClk, iRst_n     pixel clock, asynchronous active-low reset
//   iEn              run request; frames always complete once started
//   iMode            0 bars, 1 gray ramp, 2 checkerboard, 3 solid
//   iSolid           {R,G,B} used by the solid pattern
//   oR/oG/oB         pixel data, zero outside active pixels
//   oHSync/oVSync    sync regions; oLineValid active pixels;
//   oFrameValid      active lines; oBusy state RUN or DRAIN
// All outputs are registered one cycle after the raster position they describe.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int CHK_LOG2 = 4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEn,
    input  logic [1:0]  iMode,
    input  logic [23:0] iSolid,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oLineValid,
    output logic        oFrameValid,
    output logic        oBusy
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    state_e         state, state_next;
    logic           running;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           h_active, h_sync, v_active, v_sync, line_last, frame_last;
    logic           frame_start;
    mode_e          mode_q, mode_eff;
    rgb_t           solid_q, solid_eff, pixel;
    logic [BW-1:0]  bar_cnt;
    logic [2:0]     bar_idx;
    logic [HW-1:0]  h_chk;
    logic [VW-1:0]  v_chk;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk       (iClk),
        .rst_n     (iRst_n),
        .en        (running),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .h_active  (h_active),
        .h_sync    (h_sync),
        .v_active  (v_active),
        .v_sync    (v_sync),
        .line_last (line_last),
        .frame_last(frame_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= ST_IDLE;
        else         state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational blocks assign a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (iEn) state_next = ST_RUN;
            ST_RUN:   if (!iEn) state_next = frame_last ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (iEn)             state_next = ST_RUN;
                else if (frame_last) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The IDLE->RUN edge does not advance the counters, so the first RUN
    // cycle sits at (0,0).
    always_comb begin
        running = (state != ST_IDLE);
    end

    // Shadow mode/solid latch at frame start; the (0,0) pixel itself uses the
    // live inputs so the new setting covers the whole frame.
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign mode_eff    = frame_start ? mode_e'(iMode) : mode_q;
    assign solid_eff   = frame_start ? rgb_t'(iSolid) : solid_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            mode_q  <= MODE_BARS;
            solid_q <= '0;
        end else if (running && frame_start) begin
            mode_q  <= mode_e'(iMode);
            solid_q <= rgb_t'(iSolid);
        end
    end

    // Bar index tracks h_cnt with a bar-width counter instead of a divide.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (!running || line_last) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_cnt <= bar_cnt + 1'b1;
        end
    end

    assign h_chk = h_cnt >> CHK_LOG2;
    assign v_chk = v_cnt >> CHK_LOG2;

    // Pattern mux; blanking is black.
    always_comb begin
        pixel = '0;
        if (h_active && v_active) begin
            unique case (mode_eff)
                MODE_BARS:    pixel = rgb_t'(BAR_LUT[bar_idx]);
                MODE_RAMP:    pixel = '{r: 8'(h_cnt), g: 8'(h_cnt), b: 8'(h_cnt)};
                MODE_CHECKER: pixel = (h_chk[0] ^ v_chk[0]) ? rgb_t'(24'hFFFFFF) : '0;
                MODE_SOLID:   pixel = solid_eff;
                default:      pixel = '0;
            endcase
        end
    end

    // Output registers: everything sees the same one-cycle latency.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n || 1'b0) begin
            {oR, oG, oB} <= '0;
            oHSync       <= 1'b0;
            oVSync       <= 1'b0;
            oLineValid   <= 1'b0;
            oFrameValid  <= 1'b0;
            oBusy        <= 1'b0;
        end else if (!running) begin
            {oR, oG, oB} <= '0;
            oHSync       <= 1'b0;
            oVSync       <= 1'b0;
            oLineValid   <= 1'b0;
            oFrameValid  <= 1'b0;
            oBusy        <= 1'b0;
        end else begin
            {oR, oG, oB} <= pixel;
            oHSync       <= h_sync;
            oVSync       <= v_sync;
            oLineValid   <= h_active && v_active;
            oFrameValid  <= v_active;
            oBusy        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen with a 24x8 raster.
module tb_video_pattern_gen;

    localparam int H_ACT = 16, H_FP = 2, H_SW = 3, H_BP = 3;
    localparam int V_ACT = 4,  V_FP = 1, V_SW = 2, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;   // 24
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;   // 8
    localparam int CHK   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid = 24'h0;
    logic [7:0]  r, g, b;
    logic        hs, vs, lv, fv, busy;

    video_pattern_gen #(
        .H_ACTIVE(H_ACT), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
        .V_ACTIVE(V_ACT), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP),
        .CHK_LOG2(CHK)
    ) dut (
        .iClk(clk), .iRst_n(rst_n), .iEn(en), .iMode(mode), .iSolid(solid),
        .oR(r), .oG(g), .oB(b), .oHSync(hs), .oVSync(vs),
        .oLineValid(lv), .oFrameValid(fv), .oBusy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // {busy, fv, lv, vs, hs, R, G, B}
    function automatic logic [31:0] dut_vec();
        return {3'b0, busy, fv, lv, vs, hs, r, g, b};
    endfunction

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
    int          m_state = M_IDLE;
    int          m_h = 0, m_v = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_solid = 24'h0;
    logic [31:0] sb[$];

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [31:0] model_out();
        logic [31:0] o;
        logic [1:0]  md;
        logic [23:0] sc, px;
        logic        act;
        o = '0;
        if (m_state != M_IDLE) begin
            md  = (m_h == 0 && m_v == 0) ? mode  : m_mode;
            sc  = (m_h == 0 && m_v == 0) ? solid : m_solid;
            act = (m_h < H_ACT) && (m_v < V_ACT);
            px  = 24'h0;
            if (act) begin
                case (md)
                    2'd0: px = bars[m_h / (H_ACT / 8)];
                    2'd1: px = {3{8'(m_h % 256)}};
                    2'd2: px = ((((m_h >> CHK) ^ (m_v >> CHK)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
                    default: px = sc;
                endcase
            end
            o[28] = 1'b1;
            o[27] = (m_v < V_ACT);
            o[26] = act;
            o[25] = (m_v >= V_ACT + V_FP) && (m_v < V_ACT + V_FP + V_SW);
            o[24] = (m_h >= H_ACT + H_FP) && (m_h < H_ACT + H_FP + H_SW);
            o[23:0] = px;
        end
        return o;
    endfunction

    task automatic model_advance();
        int  old;
        bit  last;
        old  = m_state;
        last = (m_h == H_TOT - 1) && (m_v == V_TOT - 1);
        if (old != M_IDLE && m_h == 0 && m_v == 0) begin
            m_mode  = mode;
            m_solid = solid;
        end
        case (old)
            M_IDLE:  if (en) m_state = M_RUN;
            M_RUN:   if (!en) m_state = last ? M_IDLE : M_DRAIN;
            default: if (en) m_state = M_RUN; else if (last) m_state = M_IDLE;
        endcase
        if (old != M_IDLE) begin
            if (m_h == H_TOT - 1) begin
                m_h = 0;
                m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_h = 0; m_v = 0;
        m_mode = 2'd0; m_solid = 24'h0;
        sb.delete();
    endtask

    // Push expectation for the coming edge, then move to edge+2.
    task automatic step();
        sb.push_back(model_out());
        model_advance();
        @(posedge clk);
        #2;
    endtask

    function automatic int pos();
        return m_v * H_TOT + m_h;
    endfunction

    task automatic steps_until(input int target);
        for (int i = 0; i < 400; i++) begin
            if (m_state != M_IDLE && pos() == target) return;
            step();
        end
        check("reach_pos", pos(), target);
    endtask

    // ---------------- monitor ----------------
    int lv_seen = 0, hs_seen = 0, vs_seen = 0;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            check("pixel_out", dut_vec(), sb.pop_front());
            lv_seen += int'(lv);
            hs_seen += int'(hs);
            vs_seen += int'(vs);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_out", dut_vec(), 32'h0);

        // Color bars: enable, one IDLE edge then a full frame.
        rst_n = 1'b1;
        mode  = 2'd0;
        en    = 1'b1;
        lv_seen = 0; hs_seen = 0; vs_seen = 0;
        step();
        repeat (H_TOT * V_TOT) step();
        check("lv_per_frame", lv_seen, H_ACT * V_ACT);
        check("hs_per_frame", hs_seen, H_SW * V_TOT);
        check("vs_per_frame", vs_seen, V_SW * H_TOT);

        // Checkerboard frame, then solid requested mid-frame.
        mode = 2'd2;
        steps_until(100);
        mode  = 2'd3;
        solid = 24'h123456;
        steps_until(0);
        repeat (30) step();

        // Drop enable at frame cycle 50: frame completes, then idle.
        steps_until(50);
        en = 1'b0;
        repeat (200) step();

        // Restart, drop enable, re-raise during DRAIN.
        mode = 2'd0;
        en   = 1'b1;
        step();
        steps_until(50);
        en = 1'b0;
        steps_until(120);
        en = 1'b1;
        steps_until(0);
        repeat (30) step();

        // Asynchronous reset between edges mid-line.
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst", dut_vec(), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_hold", dut_vec(), 32'h0);
        mode  = 2'd1;
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        repeat (H_TOT * V_TOT + 10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
